// File: rtl/clk_mgmt_pkg.sv
// Shared clock-management types and default timing constants for the MMCM
// lock supervisor and the clk_mgmt_eth users.
package clk_mgmt_pkg;

    typedef enum logic [2:0] {
        RST_MMCM,
        WAIT_LOCK,
        STABLE,
        READY,
        FAILED
    } sup_st_t;

    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 100000;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES   = 4;
    localparam int unsigned DEF_CNT_W         = 8;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clk_lock_supervisor_if.sv
// MMCM lock handshake and downstream reset/status bundle. The supervisor is the
// master; the MMCM wrapper and reset consumers sit on the slave side.
interface clk_lock_supervisor_if
    import clk_mgmt_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             mmcm_rst_o;
    logic             mmcm_locked_i;
    logic             restart_i;
    logic             sys_rst_o;
    logic             ready_o;
    logic             fail_o;
    logic [CNT_W-1:0] lock_loss_cnt_o;

    modport master (
        input  mmcm_locked_i,
        input  restart_i,
        output mmcm_rst_o,
        output sys_rst_o,
        output ready_o,
        output fail_o,
        output lock_loss_cnt_o
    );

    modport slave (
        output mmcm_locked_i,
        output restart_i,
        input  mmcm_rst_o,
        input  sys_rst_o,
        input  ready_o,
        input  fail_o,
        input  lock_loss_cnt_o
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from before the edge, forming a true 2-flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/clk_lock_supervisor.sv
// Drives the MMCM reset, qualifies its LOCKED output and holds downstream logic
// in reset until lock has been stable; re-resets the MMCM on lock loss.
module clk_lock_supervisor
    import clk_mgmt_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    clk_lock_supervisor_if.master sup
);
    localparam int unsigned TMR_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);

    sup_st_t          state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [RTY_W-1:0] retry, retry_n;
    logic [CNT_W-1:0] loss_cnt;
    logic             locked_s;
    logic             loss_inc;
    logic             mmcm_rst_q, sys_rst_q, ready_q, fail_q;

    sync_2ff u_lock_sync (
        .clk (clk_in),
        .rst (rst_in),
        .d   (sup.mmcm_locked_i),
        .q   (locked_s)
    );

    // NOTE: every variable written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        timer_n = timer + 1'b1;
        retry_n = retry;

        unique case (state)
            RST_MMCM: begin
                if (timer == RST_LAST) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                end else if (timer == TO_LAST) begin
                    retry_n = retry + 1'b1;
                    state_n = (retry_n == RTY_LIMIT) ? FAILED : RST_MMCM;
                end
            end
            STABLE: begin
                // A dropout here only restarts qualification; it is not a retry.
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                end else if (timer == STABLE_LAST) begin
                    state_n = READY;
                    retry_n = '0;
                end
            end
            READY: begin
                timer_n = '0;
                if (!locked_s) state_n = RST_MMCM;
            end
            FAILED: begin
                timer_n = '0;
                if (sup.restart_i) begin
                    state_n = RST_MMCM;
                    retry_n = '0;
                end
            end
            default: begin
                state_n = RST_MMCM;
            end
        endcase

        if (state_n != state) timer_n = '0;
    end

    assign loss_inc = (state == READY) && !locked_s;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= RST_MMCM;
            timer <= '0;
            retry <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            retry <= retry_n;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state; sys_rst_o therefore only falls on the edge entering READY.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mmcm_rst_q <= 1'b1;
            sys_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            mmcm_rst_q <= (state_n == RST_MMCM) || (state_n == FAILED);
            sys_rst_q  <= (state_n != READY);
            ready_q    <= (state_n == READY);
            fail_q     <= (state_n == FAILED);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            loss_cnt <= '0;
        end else if (loss_inc && !(&loss_cnt)) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign sup.mmcm_rst_o      = mmcm_rst_q;
    assign sup.sys_rst_o       = sys_rst_q;
    assign sup.ready_o         = ready_q;
    assign sup.fail_o          = fail_q;
    assign sup.lock_loss_cnt_o = loss_cnt;
endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Directed bench for clk_lock_supervisor with shortened timing parameters;
// inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_clk_lock_supervisor;
    localparam int unsigned CNT_W = 4;

    logic clk_in = 1'b0;
    logic rst_in;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total    = 0;

    clk_lock_supervisor_if #(.CNT_W(CNT_W)) sup_if ();

    clk_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .sup    (sup_if)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check_rst_vals(input string tag);
        check({tag, "_mmcm_rst"}, sup_if.mmcm_rst_o, 1);
        check({tag, "_sys_rst"},  sup_if.sys_rst_o, 1);
        check({tag, "_ready"},    sup_if.ready_o, 0);
        check({tag, "_fail"},     sup_if.fail_o, 0);
        check({tag, "_cnt"},      sup_if.lock_loss_cnt_o, 0);
    endtask

    initial begin
        rst_in               = 1'b0;
        sup_if.mmcm_locked_i = 1'b0;
        sup_if.restart_i     = 1'b0;
        #2 rst_in = 1'b1;
        #1 check_rst_vals("por");
        step(2);
        rst_in = 1'b0;

        // 1: first lock-up, MMCM reset is exactly 4 cycles wide
        step(3);
        check("t1_mmcm_rst_c3", sup_if.mmcm_rst_o, 1);
        step(1);
        check("t1_mmcm_rst_c4", sup_if.mmcm_rst_o, 0);
        check("t1_sys_rst_wait", sup_if.sys_rst_o, 1);
        step(3);
        sup_if.mmcm_locked_i = 1'b1;
        step(10);
        check("t1_ready_early", sup_if.ready_o, 0);
        step(1);
        check("t1_ready", sup_if.ready_o, 1);
        check("t1_sys_rst", sup_if.sys_rst_o, 0);
        check("t1_cnt", sup_if.lock_loss_cnt_o, 0);

        // 3: one-cycle lock drop in READY
        sup_if.mmcm_locked_i = 1'b0;
        step(1);
        sup_if.mmcm_locked_i = 1'b1;
        step(1);
        check("t3_sys_rst_e2", sup_if.sys_rst_o, 0);
        step(1);
        check("t3_sys_rst_e3", sup_if.sys_rst_o, 1);
        check("t3_ready_e3", sup_if.ready_o, 0);
        check("t3_mmcm_rst_e3", sup_if.mmcm_rst_o, 1);
        check("t3_cnt", sup_if.lock_loss_cnt_o, 1);
        step(4);
        check("t3_mmcm_rel", sup_if.mmcm_rst_o, 0);
        step(8);
        check("t3_ready_early", sup_if.ready_o, 0);
        step(1);
        check("t3_ready", sup_if.ready_o, 1);

        // 4: one timeout (retry=1), then a dropout during STABLE
        sup_if.mmcm_locked_i = 1'b0;
        step(3);
        check("t4_sys_rst", sup_if.sys_rst_o, 1);
        check("t4_cnt", sup_if.lock_loss_cnt_o, 2);
        step(23);
        check("t4_before_to", sup_if.mmcm_rst_o, 0);
        step(1);
        check("t4_timeout", sup_if.mmcm_rst_o, 1);
        check("t4_retry1", dut.retry, 1);
        step(4);
        check("t4_mmcm_rel", sup_if.mmcm_rst_o, 0);
        sup_if.mmcm_locked_i = 1'b1;
        step(6);
        sup_if.mmcm_locked_i = 1'b0;
        step(1);
        sup_if.mmcm_locked_i = 1'b1;
        step(2);
        check("t4_glitch_ready", sup_if.ready_o, 0);
        check("t4_glitch_mmcm", sup_if.mmcm_rst_o, 0);
        check("t4_retry_kept", dut.retry, 1);
        step(8);
        check("t4_ready_early", sup_if.ready_o, 0);
        step(1);
        check("t4_ready", sup_if.ready_o, 1);
        check("t4_retry_clr", dut.retry, 0);

        // 2: lock never returns -> two reset pulses, then FAILED; restart
        sup_if.mmcm_locked_i = 1'b0;
        step(3);
        check("t2_cnt", sup_if.lock_loss_cnt_o, 3);
        step(4);
        check("t2_p1_end", sup_if.mmcm_rst_o, 0);
        step(19);
        check("t2_gap1_end", sup_if.mmcm_rst_o, 0);
        step(1);
        check("t2_p2_start", sup_if.mmcm_rst_o, 1);
        check("t2_p2_fail", sup_if.fail_o, 0);
        step(4);
        check("t2_p2_end", sup_if.mmcm_rst_o, 0);
        step(19);
        check("t2_gap2_mmcm", sup_if.mmcm_rst_o, 0);
        check("t2_gap2_fail", sup_if.fail_o, 0);
        step(1);
        check("t2_failed", sup_if.fail_o, 1);
        check("t2_failed_mmcm", sup_if.mmcm_rst_o, 1);
        check("t2_failed_sys", sup_if.sys_rst_o, 1);
        step(30);
        check("t2_held_fail", sup_if.fail_o, 1);
        check("t2_held_mmcm", sup_if.mmcm_rst_o, 1);
        sup_if.restart_i = 1'b1;
        step(1);
        sup_if.restart_i = 1'b0;
        check("t2_restart_fail", sup_if.fail_o, 0);
        check("t2_restart_mmcm", sup_if.mmcm_rst_o, 1);
        step(3);
        check("t2_pulse_c4", sup_if.mmcm_rst_o, 1);
        step(1);
        check("t2_pulse_end", sup_if.mmcm_rst_o, 0);
        sup_if.restart_i = 1'b1;
        step(1);
        sup_if.restart_i = 1'b0;
        check("t2_restart_ignored", sup_if.mmcm_rst_o, 0);
        sup_if.mmcm_locked_i = 1'b1;
        step(10);
        check("t2_ready_early", sup_if.ready_o, 0);
        step(1);
        check("t2_ready", sup_if.ready_o, 1);

        // 5: asynchronous reset in READY, checked before any clock edge
        #2 rst_in = 1'b1;
        #1 check_rst_vals("t5");
        step(1);
        rst_in = 1'b0;
        step(3);
        check("t5_mmcm_c3", sup_if.mmcm_rst_o, 1);
        step(1);
        check("t5_mmcm_rel", sup_if.mmcm_rst_o, 0);
        step(8);
        check("t5_ready_early", sup_if.ready_o, 0);
        step(1);
        check("t5_ready", sup_if.ready_o, 1);

        // 6: 17 lock losses, counter saturates at 15
        for (int i = 0; i < 17; i++) begin
            sup_if.mmcm_locked_i = 1'b0;
            step(3);
            check($sformatf("t6_cnt_%0d", i), sup_if.lock_loss_cnt_o, (i + 1 > 15) ? 15 : i + 1);
            sup_if.mmcm_locked_i = 1'b1;
            step(13);
            check($sformatf("t6_ready_%0d", i), sup_if.ready_o, 1);
        end
        check("t6_sat", sup_if.lock_loss_cnt_o, 15);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
